mem2p_port_arbiter: RTL

- Shares the 64-entry two-port memory wrapper (read port A, write port B) between two requesters, e.g. the multiplier write-back/block-read engine (requester 0) and a host/debug agent (requester 1).
- Write port and read port are arbitrated independently, each round-robin.
- Memory commands are registered. Read data is routed back to the requester that owns it, tagged in order.
- A same-address read is held off behind a concurrent write, so read-after-write returns new data.

---
 rtl/mem2p_port_arbiter_pkg.sv | 12 +
 rtl/mem2p_port_arbiter_if.sv | 27 ++
 rtl/mem2p_port_arbiter_rr_arb2.sv | 30 +++
 rtl/mem2p_port_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/mem2p_port_arbiter_pkg.sv
// Shared types and limits for the two-port memory arbiter and its round-robin sub-block.
package mem2p_arb_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int MAX_RD_LAT = 4;

  typedef logic req_id_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic logic [1:0] idToOneHot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem2p_port_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter: write and read channels for requesters 0 and 1.
interface mem2p_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              wr_req0, wr_req1;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1;
  logic [WIDTH-1:0]  wr_data0, wr_data1;
  logic              wr_gnt0, wr_gnt1;
  logic              rd_req0, rd_req1;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic              rd_gnt0, rd_gnt1;
  logic              rd_rvalid0, rd_rvalid1;
  logic [WIDTH-1:0]  rd_rdata;

  modport master (
    output wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req0, rd_req1, rd_addr0, rd_addr1,
    input  wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_rvalid0, rd_rvalid1, rd_rdata
  );

  modport slave (
    input  wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req0, rd_req1, rd_addr0, rd_addr1,
    output wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1, rd_rvalid0, rd_rvalid1, rd_rdata
  );
endinterface

// File: rtl/mem2p_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester not granted most recently wins;
// the pointer only moves on an actual grant, so a blocked or withdrawn request leaves it alone.
module rr_arb2
  import mem2p_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt,
  output req_id_t    winner
);
  req_id_t lastQ;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~lastQ;
    else if (req[1])  winner = 1'b1;
  end

  always_comb begin
    gnt = 2'b00;
    if (rst && !block && (req != 2'b00)) gnt = idToOneHot(winner);
  end

  always_ff @(posedge clk) begin
    if (!rst)               lastQ <= 1'b1;
    else if (gnt != 2'b00)  lastQ <= winner;
  end
endmodule

// File: rtl/mem2p_port_arbiter.sv
// Shares a two-port memory (read port A, write port B) between two requesters with independent
// round-robin arbitration per port, registered memory commands and in-order tagged read return.
module mem2p_port_arbiter
  import mem2p_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem2p_port_arbiter_if.slave bus,
  output logic              mem_cenA,
  output logic [ADDR_W-1:0] mem_aA,
  output logic              mem_cenB,
  output logic [ADDR_W-1:0] mem_aB,
  output logic [WIDTH-1:0]  mem_d,
  input  logic [WIDTH-1:0]  mem_q,
  output logic              idle
);
  logic [1:0]        wrGnt, rdGnt;
  req_id_t           wrWin, rdWin;
  logic [ADDR_W-1:0] wrAddr, rdAddr;
  logic [WIDTH-1:0]  wrData;
  logic              rawHold;
  logic [RD_LAT:0]   tagV;
  logic [RD_LAT:0]   tagId;

  rr_arb2 uWrArb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.wr_req1, bus.wr_req0}),
    .block  (1'b0),
    .gnt    (wrGnt),
    .winner (wrWin)
  );

  assign wrAddr = wrWin ? bus.wr_addr1 : bus.wr_addr0;
  assign wrData = wrWin ? bus.wr_data1 : bus.wr_data0;
  assign rdAddr = rdWin ? bus.rd_addr1 : bus.rd_addr0;

  // Hold the read off when it would race a same-cycle write to the same word.
  assign rawHold = (wrGnt != 2'b00) && (bus.rd_req0 || bus.rd_req1) && (rdAddr == wrAddr);

  rr_arb2 uRdArb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.rd_req1, bus.rd_req0}),
    .block  (rawHold),
    .gnt    (rdGnt),
    .winner (rdWin)
  );

  assign bus.wr_gnt0 = wrGnt[0];
  assign bus.wr_gnt1 = wrGnt[1];
  assign bus.rd_gnt0 = rdGnt[0];
  assign bus.rd_gnt1 = rdGnt[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_cenA <= 1'b1;
      mem_aA   <= '0;
      mem_cenB <= 1'b1;
      mem_aB   <= '0;
      mem_d    <= '0;
      tagV     <= '0;
      tagId    <= '0;
    end else begin
      mem_cenB <= (wrGnt == 2'b00);
      if (wrGnt != 2'b00) begin
        mem_aB <= wrAddr;
        mem_d  <= wrData;
      end
      mem_cenA <= (rdGnt == 2'b00);
      if (rdGnt != 2'b00) mem_aA <= rdAddr;
      // Stage k holds the owner of the read granted k+1 cycles ago; the last stage meets mem_q.
      tagV  <= {tagV[RD_LAT-1:0], (rdGnt != 2'b00)};
      tagId <= {tagId[RD_LAT-1:0], rdWin};
    end
  end

  assign bus.rd_rvalid0 = rst && tagV[RD_LAT] && !tagId[RD_LAT];
  assign bus.rd_rvalid1 = rst && tagV[RD_LAT] &&  tagId[RD_LAT];
  assign bus.rd_rdata   = mem_q;

  assign idle = !rst || (!bus.wr_req0 && !bus.wr_req1 && !bus.rd_req0 && !bus.rd_req1
                         && (tagV == '0));
endmodule
